// File: rtl/q_learning_scheduler.sv
// Q-learning update scheduler.
// Buffers environment transitions, issues them to the Q-learning core one per
// cycle, and holds back any transition whose state or next state collides with
// an update still outstanding in the core. A dump request drains the core and
// then pulses the table write-out.
//
// Handshake: an input transition moves only on a clock edge where s_valid and
// s_ready are both high. The core sees one o_core_valid pulse per issue and
// answers with one i_core_done pulse per issue, in issue order.
module q_learning_scheduler #(
  parameter int STATES_WIDTH  = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_INFLIGHT  = 4,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [STATES_WIDTH-1:0]  s_st,
  input  logic [STATES_WIDTH-1:0]  s_next_st,
  input  logic [ACTIONS_WIDTH-1:0] s_at,
  input  logic [DATA_WIDTH-1:0]    s_rt,
  output logic                     o_core_valid,
  output logic [STATES_WIDTH-1:0]  o_core_st,
  output logic [STATES_WIDTH-1:0]  o_core_next_st,
  output logic [ACTIONS_WIDTH-1:0] o_core_at,
  output logic [DATA_WIDTH-1:0]    o_core_rt,
  input  logic                     i_core_done,
  input  logic                     i_dump_req,
  output logic                     o_write_file_en,
  output logic [CNT_W-1:0]         o_inflight_cnt,
  output logic [31:0]              o_update_cnt,
  output logic                     o_busy,
  output logic [1:0]               o_fsm_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [AW:0]      FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_CNT       = CNT_W'(MAX_INFLIGHT);
  localparam logic [IW-1:0]    IFL_LAST      = IW'(MAX_INFLIGHT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Input transition FIFO
  logic [STATES_WIDTH-1:0]  fifo_st_q [FIFO_DEPTH];
  logic [STATES_WIDTH-1:0]  fifo_nx_q [FIFO_DEPTH];
  logic [ACTIONS_WIDTH-1:0] fifo_at_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_rt_q [FIFO_DEPTH];
  logic [AW-1:0]            fifo_wr_q, fifo_rd_q;
  logic [AW:0]              fifo_cnt_q, fifo_cnt_d;
  logic                     fifo_full, fifo_empty, push, ready_q;

  // In-flight queue (updates issued to the core, not yet done)
  logic [STATES_WIDTH-1:0]  ifl_st_q [MAX_INFLIGHT];
  logic [DATA_WIDTH-1:0]    ifl_rt_q [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0]  ifl_vld_q;
  logic [IW-1:0]            ifl_wr_q, ifl_rd_q;
  logic [CNT_W-1:0]         ifl_cnt_q, ifl_cnt_d;
  logic [DATA_WIDTH-1:0]    last_rt_q;

  logic                     issue, hazard, done_acc;
  logic [31:0]              upd_cnt_q;
  logic                     core_valid_q;
  logic [STATES_WIDTH-1:0]  core_st_q, core_nx_q;
  logic [ACTIONS_WIDTH-1:0] core_at_q;

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  // ready_q keeps s_ready low while reset is asserted
  assign s_ready    = ready_q & ~fifo_full;
  assign push       = s_valid & s_ready;
  // A done with nothing outstanding is a stray pulse and is dropped
  assign done_acc   = i_core_done & (ifl_cnt_q != '0);

  // Hazard: head collides with any outstanding update, including one retiring now
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (ifl_vld_q[i] && ((ifl_st_q[i] == fifo_st_q[fifo_rd_q]) ||
                           (ifl_st_q[i] == fifo_nx_q[fifo_rd_q]))) begin
        hazard = 1'b1;
      end
    end
  end

  // Issue decision for the FIFO head
  always_comb begin
    issue = (state_q == ST_RUN) && i_enable && !fifo_empty &&
            (ifl_cnt_q < MAX_CNT) && !hazard;
  end

  // Occupancy bookkeeping for both queues
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, issue})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    ifl_cnt_d = ifl_cnt_q;
    case ({issue, done_acc})
      2'b10:   ifl_cnt_d = ifl_cnt_q + CNT_W'(1);
      2'b01:   ifl_cnt_d = ifl_cnt_q - CNT_W'(1);
      default: ifl_cnt_d = ifl_cnt_q;
    endcase
  end

  // FIFO payload storage; contents are only read when the entry is occupied
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_st_q[fifo_wr_q] <= s_st;
      fifo_nx_q[fifo_wr_q] <= s_next_st;
      fifo_at_q[fifo_wr_q] <= s_at;
      fifo_rt_q[fifo_wr_q] <= s_rt;
    end
  end

  // In-flight payload storage; guarded by ifl_vld_q
  always_ff @(posedge clk) begin
    if (issue) begin
      ifl_st_q[ifl_wr_q] <= fifo_st_q[fifo_rd_q];
      ifl_rt_q[ifl_wr_q] <= fifo_rt_q[fifo_rd_q];
    end
  end

  // Pointers, counters, valid bits and registered core outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_cnt_q   <= '0;
      ifl_vld_q    <= '0;
      ifl_wr_q     <= '0;
      ifl_rd_q     <= '0;
      ifl_cnt_q    <= '0;
      last_rt_q    <= '0;
      upd_cnt_q    <= '0;
      core_valid_q <= 1'b0;
      core_st_q    <= '0;
      core_nx_q    <= '0;
      core_at_q    <= '0;
    end else begin
      ready_q    <= 1'b1;
      fifo_cnt_q <= fifo_cnt_d;
      ifl_cnt_q  <= ifl_cnt_d;
      if (push)  fifo_wr_q <= fifo_wr_q + AW'(1);
      if (issue) fifo_rd_q <= fifo_rd_q + AW'(1);
      if (issue) begin
        ifl_vld_q[ifl_wr_q] <= 1'b1;
        ifl_wr_q <= (ifl_wr_q == IFL_LAST) ? '0 : ifl_wr_q + IW'(1);
      end
      if (done_acc) begin
        ifl_vld_q[ifl_rd_q] <= 1'b0;
        ifl_rd_q  <= (ifl_rd_q == IFL_LAST) ? '0 : ifl_rd_q + IW'(1);
        last_rt_q <= ifl_rt_q[ifl_rd_q];
        upd_cnt_q <= upd_cnt_q + 32'd1;
      end
      core_valid_q <= issue;
      if (issue) begin
        core_st_q <= fifo_st_q[fifo_rd_q];
        core_nx_q <= fifo_nx_q[fifo_rd_q];
        core_at_q <= fifo_at_q[fifo_rd_q];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state; a dump request with nothing outstanding skips DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_dump_req) state_d = (ifl_cnt_d == '0) ? ST_DUMP : ST_DRAIN;
      ST_DRAIN: if (ifl_cnt_q == '0) state_d = ST_DUMP;
      ST_DUMP:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_write_file_en = (state_q == ST_DUMP);
    o_fsm_state     = state_q;
  end

  // Reward of the oldest outstanding update, or the last retired one when idle
  always_comb begin
    o_core_rt = ifl_vld_q[ifl_rd_q] ? ifl_rt_q[ifl_rd_q] : last_rt_q;
  end

  assign o_core_valid   = core_valid_q;
  assign o_core_st      = core_st_q;
  assign o_core_next_st = core_nx_q;
  assign o_core_at      = core_at_q;
  assign o_inflight_cnt = ifl_cnt_q;
  assign o_update_cnt   = upd_cnt_q;
  assign o_busy         = !fifo_empty || (ifl_cnt_q != '0);

endmodule

// File: tb/tb_q_learning_scheduler.sv
// Directed testbench for q_learning_scheduler.
module tb_q_learning_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_st = '0, s_next_st = '0;
  logic [1:0]  s_at = '0;
  logic [15:0] s_rt = '0;
  logic        o_core_valid;
  logic [3:0]  o_core_st, o_core_next_st;
  logic [1:0]  o_core_at;
  logic [15:0] o_core_rt;
  logic        i_core_done = 1'b0;
  logic        i_dump_req = 1'b0;
  logic        o_write_file_en;
  logic [2:0]  o_inflight_cnt;
  logic [31:0] o_update_cnt;
  logic        o_busy;
  logic [1:0]  o_fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_upd = 0;
  logic [3:0] iss_log[$];
  logic [3:0] exp_q[$];

  q_learning_scheduler dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_st(s_st), .s_next_st(s_next_st), .s_at(s_at), .s_rt(s_rt),
    .o_core_valid(o_core_valid), .o_core_st(o_core_st),
    .o_core_next_st(o_core_next_st), .o_core_at(o_core_at), .o_core_rt(o_core_rt),
    .i_core_done(i_core_done), .i_dump_req(i_dump_req),
    .o_write_file_en(o_write_file_en), .o_inflight_cnt(o_inflight_cnt),
    .o_update_cnt(o_update_cnt), .o_busy(o_busy), .o_fsm_state(o_fsm_state)
  );

  // clock / cycle counter / issue monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && o_core_valid) iss_log.push_back(o_core_st);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] st, input logic [3:0] nx,
                      input logic [1:0] at, input logic [15:0] rt, output int acc);
    int guard;
    guard = 0;
    s_valid = 1'b1; s_st = st; s_next_st = nx; s_at = at; s_rt = rt;
    while (!s_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      $display("FAIL push_timeout: s_ready stayed %0b, required 1", s_ready);
      n_errors++;
    end
    step();
    acc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic pulse_done();
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_checks++; if (s_ready !== 1'b0) begin $display("FAIL rst_ready_low: got %0b exp 0", s_ready); n_errors++; end
    n_checks++; if (o_core_valid !== 1'b0 || o_write_file_en !== 1'b0) begin $display("FAIL rst_pulses: valid %0b wfe %0b exp 0", o_core_valid, o_write_file_en); n_errors++; end
    n_checks++; if (o_inflight_cnt !== 3'd0 || o_update_cnt !== 32'd0 || o_busy !== 1'b0) begin $display("FAIL rst_counts: infl %0d upd %0d busy %0b exp 0", o_inflight_cnt, o_update_cnt, o_busy); n_errors++; end
    n_checks++; if (o_core_st !== 4'd0 || o_core_next_st !== 4'd0 || o_core_at !== 2'd0 || o_core_rt !== 16'd0) begin $display("FAIL rst_fields: st %0d nx %0d at %0d rt %0d exp 0", o_core_st, o_core_next_st, o_core_at, o_core_rt); n_errors++; end
    rst_n = 1'b1;
    step();
    n_checks++; if (s_ready !== 1'b1) begin $display("FAIL rst_ready_after: got %0b exp 1", s_ready); n_errors++; end
  endtask

  task automatic test_single();
    int acc;
    i_enable = 1'b1;
    push(4'd1, 4'd2, 2'd0, 16'd5, acc);
    n_checks++; if (o_core_valid !== 1'b0) begin $display("FAIL single_early: valid %0b exp 0", o_core_valid); n_errors++; end
    step();
    n_checks++; if (o_core_valid !== 1'b1 || o_core_st !== 4'd1 || o_core_next_st !== 4'd2 || o_core_at !== 2'd0) begin $display("FAIL single_issue: v %0b st %0d nx %0d at %0d exp 1/1/2/0", o_core_valid, o_core_st, o_core_next_st, o_core_at); n_errors++; end
    n_checks++; if (o_core_rt !== 16'd5 || o_inflight_cnt !== 3'd1) begin $display("FAIL single_rt: rt %0d infl %0d exp 5/1", o_core_rt, o_inflight_cnt); n_errors++; end
    step(); step(); step();
    n_checks++; if (o_core_valid !== 1'b0 || o_core_rt !== 16'd5 || o_busy !== 1'b1) begin $display("FAIL single_hold: v %0b rt %0d busy %0b exp 0/5/1", o_core_valid, o_core_rt, o_busy); n_errors++; end
    pulse_done(); exp_upd++;
    n_checks++; if (o_update_cnt !== 32'(exp_upd) || o_inflight_cnt !== 3'd0 || o_busy !== 1'b0) begin $display("FAIL single_done: upd %0d infl %0d busy %0b exp %0d/0/0", o_update_cnt, o_inflight_cnt, o_busy, exp_upd); n_errors++; end
    n_checks++; if (o_core_rt !== 16'd5) begin $display("FAIL single_rt_held: rt %0d exp 5", o_core_rt); n_errors++; end
    pulse_done();
    n_checks++; if (o_update_cnt !== 32'(exp_upd) || o_inflight_cnt !== 3'd0) begin $display("FAIL stray_done: upd %0d infl %0d exp %0d/0", o_update_cnt, o_inflight_cnt, exp_upd); n_errors++; end
  endtask

  task automatic test_hazard();
    int acc;
    int early;
    push(4'd3, 4'd7, 2'd1, 16'd11, acc);
    push(4'd3, 4'd8, 2'd2, 16'd12, acc);
    n_checks++; if (o_core_valid !== 1'b1 || o_core_next_st !== 4'd7) begin $display("FAIL haz_first: v %0b nx %0d exp 1/7", o_core_valid, o_core_next_st); n_errors++; end
    early = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o_core_valid) early++;
    end
    i_core_done = 1'b1;
    step();
    i_core_done = 1'b0;
    if (o_core_valid) early++;
    n_checks++; if (early !== 0) begin $display("FAIL haz_blocked: issues %0d exp 0", early); n_errors++; end
    step(); exp_upd++;
    n_checks++; if (o_core_valid !== 1'b1 || o_core_next_st !== 4'd8 || o_core_rt !== 16'd12) begin $display("FAIL haz_second: v %0b nx %0d rt %0d exp 1/8/12", o_core_valid, o_core_next_st, o_core_rt); n_errors++; end
    pulse_done(); exp_upd++;
    push(4'd4, 4'd9, 2'd3, 16'd13, acc);
    push(4'd5, 4'd10, 2'd0, 16'd14, acc);
    n_checks++; if (o_core_valid !== 1'b1 || o_core_st !== 4'd4) begin $display("FAIL b2b_first: v %0b st %0d exp 1/4", o_core_valid, o_core_st); n_errors++; end
    step();
    n_checks++; if (o_core_valid !== 1'b1 || o_core_st !== 4'd5 || o_inflight_cnt !== 3'd2) begin $display("FAIL b2b_second: v %0b st %0d infl %0d exp 1/5/2", o_core_valid, o_core_st, o_inflight_cnt); n_errors++; end
    i_core_done = 1'b1;
    step(); step();
    i_core_done = 1'b0;
    exp_upd += 2;
    n_checks++; if (o_update_cnt !== 32'(exp_upd) || o_inflight_cnt !== 3'd0 || o_core_rt !== 16'd14) begin $display("FAIL b2b_retire: upd %0d infl %0d rt %0d exp %0d/0/14", o_update_cnt, o_inflight_cnt, o_core_rt, exp_upd); n_errors++; end
  endtask

  task automatic test_full();
    int acc;
    iss_log.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      push(4'(i), 4'(i + 8), 2'(i), 16'(100 + i), acc);
      exp_q.push_back(4'(i));
    end
    n_checks++; if (o_inflight_cnt !== 3'd4 || s_ready !== 1'b0 || o_busy !== 1'b1) begin $display("FAIL full_state: infl %0d ready %0b busy %0b exp 4/0/1", o_inflight_cnt, s_ready, o_busy); n_errors++; end
    n_checks++; if (iss_log.size() !== 4) begin $display("FAIL full_issued: %0d issues exp 4", iss_log.size()); n_errors++; end
    i_core_done = 1'b1;
    for (int k = 0; k < 8; k++) step();
    i_core_done = 1'b0;
    exp_upd += 8;
    step();
    n_checks++; if (iss_log.size() !== 8) begin $display("FAIL full_all_issued: %0d issues exp 8", iss_log.size()); n_errors++; end
    while (exp_q.size() > 0 && iss_log.size() > 0) begin
      n_checks++;
      if (iss_log[0] !== exp_q[0]) begin $display("FAIL full_order: st %0d exp %0d", iss_log[0], exp_q[0]); n_errors++; end
      void'(iss_log.pop_front());
      void'(exp_q.pop_front());
    end
    n_checks++; if (o_update_cnt !== 32'(exp_upd) || o_inflight_cnt !== 3'd0 || s_ready !== 1'b1 || o_busy !== 1'b0) begin $display("FAIL full_end: upd %0d infl %0d ready %0b busy %0b exp %0d/0/1/0", o_update_cnt, o_inflight_cnt, s_ready, o_busy, exp_upd); n_errors++; end
  endtask

  task automatic test_dump();
    int acc;
    int wfe_n, wfe_k, iss_k, bad;
    iss_log.delete();
    push(4'd1, 4'd2, 2'd0, 16'd21, acc);
    push(4'd3, 4'd4, 2'd1, 16'd22, acc);
    step();
    n_checks++; if (o_inflight_cnt !== 3'd2) begin $display("FAIL dump_setup: infl %0d exp 2", o_inflight_cnt); n_errors++; end
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    push(4'd5, 4'd6, 2'd2, 16'd23, acc);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o_core_valid || o_write_file_en) bad++;
    end
    pulse_done(); exp_upd++;
    if (o_core_valid || o_write_file_en) bad++;
    step();
    if (o_core_valid || o_write_file_en) bad++;
    n_checks++; if (bad !== 0 || iss_log.size() !== 2) begin $display("FAIL drain_quiet: events %0d issues %0d exp 0/2", bad, iss_log.size()); n_errors++; end
    pulse_done(); exp_upd++;
    wfe_n = 0; wfe_k = 0; iss_k = 0;
    if (o_write_file_en) begin wfe_n++; wfe_k = 0; end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (o_write_file_en) begin wfe_n++; wfe_k = k; end
      if (o_core_valid && iss_k == 0) iss_k = k;
    end
    n_checks++; if (wfe_n !== 1 || wfe_k < 1) begin $display("FAIL dump_pulse: pulses %0d at %0d exp 1 after done", wfe_n, wfe_k); n_errors++; end
    n_checks++; if (iss_k <= wfe_k || o_core_st !== 4'd5) begin $display("FAIL dump_resume: issue at %0d wfe at %0d st %0d exp issue after wfe st 5", iss_k, wfe_k, o_core_st); n_errors++; end
    pulse_done(); exp_upd++;
    i_dump_req = 1'b1;
    step();
    n_checks++; if (o_write_file_en !== 1'b1) begin $display("FAIL dump_idle_fast: wfe %0b exp 1", o_write_file_en); n_errors++; end
    step();
    i_dump_req = 1'b0;
    n_checks++; if (o_write_file_en !== 1'b0) begin $display("FAIL dump_once: wfe %0b exp 0", o_write_file_en); n_errors++; end
    step();
    n_checks++; if (o_write_file_en !== 1'b0 || o_update_cnt !== 32'(exp_upd)) begin $display("FAIL dump_end: wfe %0b upd %0d exp 0/%0d", o_write_file_en, o_update_cnt, exp_upd); n_errors++; end
  endtask

  task automatic test_reset_mid();
    int acc;
    int bad;
    for (int i = 1; i <= 4; i++) push(4'(i), 4'(i + 8), 2'(i), 16'(30 + i), acc);
    step();
    i_enable = 1'b0;
    for (int i = 5; i <= 8; i++) push(4'(i), 4'(i + 8), 2'(i), 16'(30 + i), acc);
    n_checks++; if (o_inflight_cnt !== 3'd4 || s_ready !== 1'b0) begin $display("FAIL mid_setup: infl %0d ready %0b exp 4/0", o_inflight_cnt, s_ready); n_errors++; end
    pulse_done(); exp_upd++;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (o_core_valid) bad++;
    end
    n_checks++; if (bad !== 0 || o_inflight_cnt !== 3'd3 || o_core_rt !== 16'd32 || o_update_cnt !== 32'(exp_upd)) begin $display("FAIL enable_off: issues %0d infl %0d rt %0d upd %0d exp 0/3/32/%0d", bad, o_inflight_cnt, o_core_rt, o_update_cnt, exp_upd); n_errors++; end
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_core_valid !== 1'b0 || o_write_file_en !== 1'b0 || s_ready !== 1'b0 || o_busy !== 1'b0) begin $display("FAIL mid_rst_ctrl: v %0b wfe %0b ready %0b busy %0b exp 0", o_core_valid, o_write_file_en, s_ready, o_busy); n_errors++; end
    n_checks++; if (o_core_st !== 4'd0 || o_core_next_st !== 4'd0 || o_core_at !== 2'd0 || o_core_rt !== 16'd0) begin $display("FAIL mid_rst_fields: st %0d nx %0d at %0d rt %0d exp 0", o_core_st, o_core_next_st, o_core_at, o_core_rt); n_errors++; end
    n_checks++; if (o_inflight_cnt !== 3'd0 || o_update_cnt !== 32'd0) begin $display("FAIL mid_rst_cnt: infl %0d upd %0d exp 0", o_inflight_cnt, o_update_cnt); n_errors++; end
    step();
    rst_n = 1'b1;
    i_enable = 1'b1;
    step();
    pulse_done();
    step();
    n_checks++; if (o_update_cnt !== 32'd0 || o_inflight_cnt !== 3'd0 || o_core_valid !== 1'b0 || s_ready !== 1'b1) begin $display("FAIL post_rst: upd %0d infl %0d v %0b ready %0b exp 0/0/0/1", o_update_cnt, o_inflight_cnt, o_core_valid, s_ready); n_errors++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hazard();
    test_full();
    test_dump();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
